hssi_rst_seq: RTL and testbench

- Per-channel reset sequencer between the HSSI wrapper CSR block and the HSSI subsystem IP.
- Inputs are level reset requests from CSR (cold, per-channel TX and RX). Outputs are active-low resets to the IP, with a guaranteed minimum pulse width.
- Waits for the IP's active-low ack and returns a level ack to CSR.
- Detects ack timeouts and reports them as sticky errors.

---
 rtl/hssi_rst_seq.sv | 197 +++++++++++++++++++
 tb/tb_hssi_rst_seq.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hssi_rst_seq.sv
// Per-channel HSSI reset sequencer: min-width active-low IP resets, ack handshake, sticky timeouts.
// Define HSSI_RST_SEQ_ACK_SYNC_EN to pass every IP ack_n through a 2-flop synchronizer.
module hssi_rst_seq #(
    parameter int unsigned NUM_CHANNELS = 16,
    parameter int unsigned MIN_ASSERT   = 8,
    parameter int unsigned ACK_TIMEOUT  = 1024
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    i_cold_rst_req,
    output logic                    o_cold_rst_ack,
    output logic                    o_ip_cold_rst_n,
    input  logic                    i_ip_cold_rst_ack_n,
    input  logic [NUM_CHANNELS-1:0] i_tx_rst_req,
    input  logic [NUM_CHANNELS-1:0] i_rx_rst_req,
    output logic [NUM_CHANNELS-1:0] o_ip_tx_rst_n,
    output logic [NUM_CHANNELS-1:0] o_ip_rx_rst_n,
    input  logic [NUM_CHANNELS-1:0] i_ip_tx_rst_ack_n,
    input  logic [NUM_CHANNELS-1:0] i_ip_rx_rst_ack_n,
    output logic [NUM_CHANNELS-1:0] o_tx_rst_ack,
    output logic [NUM_CHANNELS-1:0] o_rx_rst_ack,
    output logic [NUM_CHANNELS-1:0] o_tx_timeout,
    output logic [NUM_CHANNELS-1:0] o_rx_timeout
);

    localparam int unsigned NumSeq  = 2 * NUM_CHANNELS + 1;
    localparam int unsigned ColdIdx = 2 * NUM_CHANNELS;
    localparam int unsigned AsrtW   = $clog2(MIN_ASSERT + 1);
    localparam int unsigned TmoW    = $clog2(ACK_TIMEOUT + 1);

    localparam logic [AsrtW-1:0] AsrtLast = AsrtW'(MIN_ASSERT - 1);
    localparam logic [TmoW-1:0]  TmoHit   = TmoW'(ACK_TIMEOUT - 1);
    localparam logic [TmoW-1:0]  TmoMax   = TmoW'(ACK_TIMEOUT);

    typedef enum logic [2:0] {
        StIdle,
        StAssert,
        StWaitAck,
        StHold,
        StRelease
    } seq_state_e;

    // Lane order: TX lanes, then RX lanes, then the cold lane on top.
    logic [NumSeq-1:0] lane_req;
    logic [NumSeq-1:0] lane_ack_n;
    logic [NumSeq-1:0] lane_rst_n;
    logic [NumSeq-1:0] lane_ack;
    logic [NumSeq-1:0] lane_tmo;
    logic              cold_idle;
    logic              chan_block;
    logic              unused_cold_tmo;

    assign lane_req   = {i_cold_rst_req, i_rx_rst_req, i_tx_rst_req};
    assign lane_ack_n = {i_ip_cold_rst_ack_n, i_ip_rx_rst_ack_n, i_ip_tx_rst_ack_n};

    // The raw cold request also blocks, so a channel request rising with it never starts.
    assign chan_block = ~cold_idle | i_cold_rst_req;

    for (genvar g = 0; g < NumSeq; g++) begin : g_seq
        localparam bit IsCold = (g == ColdIdx);

        seq_state_e       state_q, state_d;
        logic [AsrtW-1:0] a_cnt_q, a_cnt_d;
        logic [TmoW-1:0]  t_cnt_q, t_cnt_d, t_cnt_inc;
        logic             rst_n_q, rst_n_d;
        logic             ack_q, ack_d;
        logic             tmo_q, tmo_d;
        logic             ack_s;
        logic             t_hit;
        logic             force_idle;
        logic             req;

`ifdef HSSI_RST_SEQ_ACK_SYNC_EN
        logic [1:0] sync_q;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                sync_q <= 2'b11;
            end else begin
                sync_q <= {sync_q[0], lane_ack_n[g]};
            end
        end

        assign ack_s = ~sync_q[1];
`else
        assign ack_s = ~lane_ack_n[g];
`endif

        assign req        = lane_req[g];
        assign force_idle = IsCold ? 1'b0 : chan_block;
        assign t_hit      = (t_cnt_q == TmoHit);
        assign t_cnt_inc  = (t_cnt_q == TmoMax) ? t_cnt_q : t_cnt_q + 1'b1;

        always_comb begin
            state_d = state_q;
            a_cnt_d = a_cnt_q;
            t_cnt_d = t_cnt_q;
            tmo_d   = tmo_q;
            if (force_idle) begin
                // Sticky timeout survives a cold-reset preemption.
                state_d = StIdle;
                a_cnt_d = '0;
                t_cnt_d = '0;
            end else begin
                unique case (state_q)
                    StIdle: begin
                        if (req) begin
                            state_d = StAssert;
                            a_cnt_d = '0;
                            tmo_d   = 1'b0;
                        end
                    end
                    StAssert: begin
                        if (a_cnt_q == AsrtLast) begin
                            state_d = StWaitAck;
                            t_cnt_d = '0;
                        end else begin
                            a_cnt_d = a_cnt_q + 1'b1;
                        end
                    end
                    StWaitAck: begin
                        if (ack_s || t_hit) begin
                            tmo_d = tmo_q | ~ack_s;
                            if (req) begin
                                state_d = StHold;
                            end else begin
                                state_d = StRelease;
                                t_cnt_d = '0;
                            end
                        end else begin
                            t_cnt_d = t_cnt_inc;
                        end
                    end
                    StHold: begin
                        if (!req) begin
                            state_d = StRelease;
                            t_cnt_d = '0;
                        end
                    end
                    StRelease: begin
                        if (!ack_s || t_hit) begin
                            tmo_d   = tmo_q | ack_s;
                            state_d = StIdle;
                            t_cnt_d = '0;
                        end else begin
                            t_cnt_d = t_cnt_inc;
                        end
                    end
                    default: begin
                        state_d = StIdle;
                    end
                endcase
            end
            rst_n_d = (state_d == StIdle) || (state_d == StRelease);
            ack_d   = (state_d == StHold) || (state_d == StRelease);
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                state_q <= StIdle;
                a_cnt_q <= '0;
                t_cnt_q <= '0;
                rst_n_q <= 1'b1;
                ack_q   <= 1'b0;
                tmo_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                a_cnt_q <= a_cnt_d;
                t_cnt_q <= t_cnt_d;
                rst_n_q <= rst_n_d;
                ack_q   <= ack_d;
                tmo_q   <= tmo_d;
            end
        end

        assign lane_rst_n[g] = rst_n_q;
        assign lane_ack[g]   = ack_q;
        assign lane_tmo[g]   = tmo_q;

        if (IsCold) begin : g_cold
            assign cold_idle = (state_q == StIdle);
        end
    end

    assign o_ip_tx_rst_n   = lane_rst_n[NUM_CHANNELS-1:0];
    assign o_ip_rx_rst_n   = lane_rst_n[ColdIdx-1:NUM_CHANNELS];
    assign o_ip_cold_rst_n = lane_rst_n[ColdIdx];
    assign o_tx_rst_ack    = lane_ack[NUM_CHANNELS-1:0];
    assign o_rx_rst_ack    = lane_ack[ColdIdx-1:NUM_CHANNELS];
    assign o_cold_rst_ack  = lane_ack[ColdIdx];
    assign o_tx_timeout    = lane_tmo[NUM_CHANNELS-1:0];
    assign o_rx_timeout    = lane_tmo[ColdIdx-1:NUM_CHANNELS];

    // The cold lane has no timeout port.
    assign unused_cold_tmo = lane_tmo[ColdIdx];

endmodule

// File: tb/tb_hssi_rst_seq.sv
// Self-checking bench for hssi_rst_seq: expected waveforms are derived from event times
// (request rise/fall, IP ack edges) rather than from a state machine copy.
module tb_hssi_rst_seq;

    localparam int NC = 4;
    localparam int MA = 8;
    localparam int AT = 64;
    localparam int NL = 2 * NC;
    localparam int VW = 2 + 6 * NC;
`ifdef HSSI_RST_SEQ_ACK_SYNC_EN
    localparam int L = 2;
`else
    localparam int L = 0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cold_req = 1'b0;
    logic          cold_ack;
    logic          ip_cold_rst_n;
    logic          cold_ack_n = 1'b1;
    logic [NC-1:0] tx_req = '0;
    logic [NC-1:0] rx_req = '0;
    logic [NC-1:0] ip_tx_rst_n, ip_rx_rst_n;
    logic [NC-1:0] tx_ack_n = '1;
    logic [NC-1:0] rx_ack_n = '1;
    logic [NC-1:0] tx_ack, rx_ack, tx_to, rx_to;

    int            n_cmp = 0;
    int            n_fail = 0;
    logic [NL-1:0] tmo_m = '0;

    always #5 clk = ~clk;

    hssi_rst_seq #(
        .NUM_CHANNELS(NC),
        .MIN_ASSERT  (MA),
        .ACK_TIMEOUT (AT)
    ) dut (
        .clk                (clk),
        .rst                (rst),
        .i_cold_rst_req     (cold_req),
        .o_cold_rst_ack     (cold_ack),
        .o_ip_cold_rst_n    (ip_cold_rst_n),
        .i_ip_cold_rst_ack_n(cold_ack_n),
        .i_tx_rst_req       (tx_req),
        .i_rx_rst_req       (rx_req),
        .o_ip_tx_rst_n      (ip_tx_rst_n),
        .o_ip_rx_rst_n      (ip_rx_rst_n),
        .i_ip_tx_rst_ack_n  (tx_ack_n),
        .i_ip_rx_rst_ack_n  (rx_ack_n),
        .o_tx_rst_ack       (tx_ack),
        .o_rx_rst_ack       (rx_ack),
        .o_tx_timeout       (tx_to),
        .o_rx_timeout       (rx_to)
    );

    function automatic logic [VW-1:0] obs_vec();
        return {ip_cold_rst_n, cold_ack, ip_tx_rst_n, ip_rx_rst_n, tx_ack, rx_ack, tx_to, rx_to};
    endfunction

    function automatic logic [VW-1:0] pack_exp(input logic c_rn, input logic c_ak,
                                               input logic [NL-1:0] rn, input logic [NL-1:0] ak,
                                               input logic [NL-1:0] to);
        return {c_rn, c_ak, rn[NC-1:0], rn[NL-1:NC], ak[NC-1:0], ak[NL-1:NC],
                to[NC-1:0], to[NL-1:NC]};
    endfunction

    function automatic int imax(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

    // Edge numbers (request rises before edge 1) at which the lane acks, releases, goes idle.
    function automatic void lane_times(input int ad, input int r, input int rd, input bit noack,
                                       output int x, output int y, output int z);
        int w;
        w = 1 + MA;
        x = noack ? w + AT : imax(w + 1, 1 + ad + L);
        y = (r >= x) ? r + 1 : x;
        z = noack ? y + 1 : imax(y + 1, y + rd + L);
    endfunction

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input int lane, input logic v);
        if (lane < NC) tx_req[lane] = v;
        else rx_req[lane-NC] = v;
    endtask

    task automatic set_ack_n(input int lane, input logic v);
        if (lane < NC) tx_ack_n[lane] = v;
        else rx_ack_n[lane-NC] = v;
    endtask

    task automatic do_reset();
        cold_req   = 1'b0;
        cold_ack_n = 1'b1;
        tx_req     = '0;
        rx_req     = '0;
        tx_ack_n   = '1;
        rx_ack_n   = '1;
        rst        = 1'b1;
        step();
        step();
        rst   = 1'b0;
        tmo_m = '0;
    endtask

    // One lane sequence: ack_n low from edge 1+ad (unless noack), req held through edge r,
    // ack_n released rd edges after rst_n rises. Every output of the block is checked per cycle.
    task automatic run_lane(input int lane, input int ad, input int r, input int rd,
                            input bit noack, input string name);
        int            x, y, z;
        logic [NL-1:0] rn, ak, to;
        logic [VW-1:0] ex, ob;
        lane_times(ad, r, rd, noack, x, y, z);
        set_req(lane, 1'b1);
        set_ack_n(lane, 1'b1);
        for (int k = 1; k <= z + 3; k++) begin
            step();
            rn       = '1;
            ak       = '0;
            to       = tmo_m;
            rn[lane] = (k >= y);
            ak[lane] = (k >= x) && (k < z);
            to[lane] = noack && (k >= x);
            ex       = pack_exp(1'b1, 1'b0, rn, ak, to);
            ob       = obs_vec();
            n_cmp++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL %s lane %0d cycle %0d: got %h, want %h", name, lane, k, ob, ex);
            end
            set_req(lane, (k + 1) <= r);
            set_ack_n(lane, noack ? 1'b1 : !(((k + 1) >= 1 + ad) && ((k + 1) < y + rd)));
        end
        tmo_m[lane] = noack;
    endtask

    task automatic test_reset();
        logic [VW-1:0] ex, ob;
        do_reset();
        rst = 1'b1;
        step();
        ex = pack_exp(1'b1, 1'b0, '1, '0, '0);
        ob = obs_vec();
        n_cmp++;
        if (ob !== ex) begin
            n_fail++;
            $display("FAIL reset_held: got %h, want %h", ob, ex);
        end
        rst = 1'b0;
        for (int k = 1; k <= 100; k++) begin
            step();
            ob = obs_vec();
            n_cmp++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL reset_idle cycle %0d: got %h, want %h", k, ob, ex);
            end
        end
    endtask

    task automatic test_tx_hold();
        run_lane(2, 5, 26, 3, 1'b0, "tx2_hold");
    endtask

    task automatic test_rx_timeout();
        run_lane(NC + 0, 1, 100, 1, 1'b1, "rx0_timeout");
    endtask

    task automatic test_req_drop();
        run_lane(3, 4, 3, 2, 1'b0, "tx3_req_drop");
    endtask

    // TX1 sits in HOLD when cold reset arrives; RX2 requests in the same cycle as cold.
    task automatic test_cold();
        int            c, rc, x1, xc, yc, zc;
        logic [NL-1:0] rn, ak, to;
        logic          crn, cak;
        logic [VW-1:0] ex, ob;
        c  = 16;
        rc = c + 30;
        x1 = imax(1 + MA + 1, 6 + L);
        xc = imax(c + MA + 1, c + 3 + L);
        yc = rc + 1;
        zc = imax(yc + 1, yc + 2 + L);
        set_req(1, 1'b1);
        set_ack_n(1, 1'b1);
        for (int k = 1; k <= zc + 3; k++) begin
            step();
            crn   = !((k >= c) && (k < yc));
            cak   = (k >= xc) && (k < zc);
            rn    = '1;
            ak    = '0;
            to    = tmo_m;
            to[1] = 1'b0;
            if (k < c) begin
                rn[1] = 1'b0;
                ak[1] = (k >= x1);
            end else if (k > zc) begin
                rn[1]      = 1'b0;
                rn[NC + 2] = 1'b0;
                to[NC + 2] = 1'b0;
            end
            if (k == c) begin
                n_cmp++;
                if (ip_cold_rst_n !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cold_latency: got %b, want 0", ip_cold_rst_n);
                end
            end else if (k != c + 1 || 1'b1) begin
                ex = pack_exp(crn, cak, rn, ak, to);
                ob = obs_vec();
                n_cmp++;
                if (ob !== ex) begin
                    n_fail++;
                    $display("FAIL cold_preempt cycle %0d: got %h, want %h", k, ob, ex);
                end
            end
            cold_req   = ((k + 1) >= c) && ((k + 1) <= rc);
            cold_ack_n = !(((k + 1) >= c + 3) && ((k + 1) < yc + 2));
            set_ack_n(1, !(((k + 1) >= 6) && ((k + 1) <= c + 1)));
            set_req(NC + 2, (k + 1) >= c);
        end
        do_reset();
    endtask

    task automatic test_rst_mid_wait();
        logic [NL-1:0] rn, ak, to;
        logic [VW-1:0] ex, ob;
        set_req(NC + 3, 1'b1);
        set_ack_n(NC + 3, 1'b1);
        for (int k = 1; k <= 12; k++) begin
            step();
            rn         = '1;
            ak         = '0;
            to         = tmo_m;
            rn[NC + 3] = 1'b0;
            to[NC + 3] = 1'b0;
            ex = pack_exp(1'b1, 1'b0, rn, ak, to);
            ob = obs_vec();
            n_cmp++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL rx3_pre_rst cycle %0d: got %h, want %h", k, ob, ex);
            end
        end
        rst = 1'b1;
        #1;
        n_cmp++;
        if (ip_rx_rst_n[3] !== 1'b1) begin
            n_fail++;
            $display("FAIL rx3_async_rst: got %b, want 1", ip_rx_rst_n[3]);
        end
        ex = pack_exp(1'b1, 1'b0, '1, '0, '0);
        ob = obs_vec();
        n_cmp++;
        if (ob !== ex) begin
            n_fail++;
            $display("FAIL async_rst_all: got %h, want %h", ob, ex);
        end
        tmo_m = '0;
        set_req(NC + 3, 1'b0);
        step();
        rst = 1'b0;
        for (int k = 1; k <= 5; k++) begin
            step();
            ob = obs_vec();
            n_cmp++;
            if (ob !== ex) begin
                n_fail++;
                $display("FAIL rx3_post_rst cycle %0d: got %h, want %h", k, ob, ex);
            end
        end
        run_lane(NC + 3, 3, 15, 2, 1'b0, "rx3_after_rst");
    endtask

    task automatic test_random();
        int  lane, ad, r, rd;
        bit  noack;
        for (int it = 0; it < 10; it++) begin
            lane  = int'($urandom_range(NL - 1, 0));
            ad    = int'($urandom_range(20, 1));
            r     = int'($urandom_range(40, 1));
            rd    = int'($urandom_range(6, 1));
            noack = ($urandom_range(3, 0) == 0);
            run_lane(lane, ad, r, rd, noack, "random");
            step();
        end
    endtask

    initial begin
        test_reset();
        test_tx_hold();
        test_rx_timeout();
        test_cold();
        test_req_drop();
        test_rst_mid_wait();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, got no finish, want finish");
        $fatal(1, "watchdog expired");
    end

endmodule
